// File: rtl/bcd_seg_display.sv
// bcd_seg_display: display back-end for the processor's 8-bit result register.
// The posted value is converted to BCD with an iterative double-dabble
// converter (one shift per clock). It is then encoded onto two 7-segment
// digits and a sign LED.
//
// Ports:
//   clk        rising-edge clock
//   Reset      asynchronous active-low reset
//   start      conversion request, sampled only while idle
//   value      8-bit result, sampled with start
//   is_signed  1 = value is two's complement, sampled with start
//   busy       conversion in progress
//   done       one-cycle pulse when new outputs take effect
//   Tens/Ones  segment drives, bit order {g,f,e,d,c,b,a}
//   LED        negative-sign indicator
//   ovf        magnitude exceeds 99 (digits show dashes)
module bcd_seg_display #(
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [7:0] value,
  input  logic       is_signed,
  output logic       busy,
  output logic       done,
  output logic [6:0] Tens,
  output logic [6:0] Ones,
  output logic       LED,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  // Blank and dash patterns in the active-low sense. The output polarity is
  // applied once, at the register input.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  state_t      state, state_nx;
  logic        neg;
  logic [7:0]  mag;
  logic [11:0] bcd;       // {H,T,O}
  logic [11:0] bcd_adj;
  logic [2:0]  cnt;
  logic [6:0]  tens_lo, ones_lo;
  logic        ovf_nx;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [6:0] pol(input logic [6:0] s);
    pol = SEG_ACTIVE_LOW ? s : ~s;
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  // After the shift it then carries correctly into the next decade.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // Encoding of the finished BCD value, consumed on the ENCODE edge.
  always_comb begin
    ovf_nx  = (bcd[11:8] != 4'd0);
    ones_lo = seg(bcd[3:0]);
    tens_lo = (BLANK_LZ && bcd[7:4] == 4'd0) ? SEG_BLANK : seg(bcd[7:4]);
    if (ovf_nx) begin
      ones_lo = SEG_DASH;
      tens_lo = SEG_DASH;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == 3'd7) state_nx = ENCODE;
      ENCODE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      neg  <= 1'b0;
      mag  <= 8'd0;
      bcd  <= 12'd0;
      cnt  <= 3'd0;
      done <= 1'b0;
      LED  <= 1'b0;
      ovf  <= 1'b0;
      Tens <= pol(SEG_BLANK);
      Ones <= pol(SEG_BLANK);
    end else begin
      done <= (state == ENCODE);
      case (state)
        IDLE: if (start) begin
          neg <= is_signed & value[7];
          // 8'h80 signed negates to 8'h80, which reads as 128 unsigned.
          mag <= (is_signed & value[7]) ? (~value + 8'd1) : value;
          bcd <= 12'd0;
          cnt <= 3'd0;
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj[10:0], mag, 1'b0};
          cnt        <= cnt + 3'd1;
        end
        ENCODE: begin
          LED  <= neg;
          ovf  <= ovf_nx;
          Tens <= pol(tens_lo);
          Ones <= pol(ones_lo);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seg_display.sv
module tb_bcd_seg_display;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] value = 8'd0;
  logic       is_signed = 1'b0;

  // Instance a: defaults. Instance b: no leading-zero blanking.
  // Instance c: active-high segment outputs.
  logic       busy_a, done_a, led_a, ovf_a;
  logic [6:0] tens_a, ones_a;
  logic       busy_b, done_b, led_b, ovf_b;
  logic [6:0] tens_b, ones_b;
  logic       busy_c, done_c, led_c, ovf_c;
  logic [6:0] tens_c, ones_c;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_seg_display #(.BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_a (
    .clk(clk), .Reset(Reset), .start(start), .value(value), .is_signed(is_signed),
    .busy(busy_a), .done(done_a), .Tens(tens_a), .Ones(ones_a), .LED(led_a), .ovf(ovf_a));
  bcd_seg_display #(.BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .Reset(Reset), .start(start), .value(value), .is_signed(is_signed),
    .busy(busy_b), .done(done_b), .Tens(tens_b), .Ones(ones_b), .LED(led_b), .ovf(ovf_b));
  bcd_seg_display #(.BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0)) u_c (
    .clk(clk), .Reset(Reset), .start(start), .value(value), .is_signed(is_signed),
    .busy(busy_c), .done(done_c), .Tens(tens_c), .Ones(ones_c), .LED(led_c), .ovf(ovf_c));

  // ---------------- behavioural model ----------------
  logic [6:0] SEGT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000};
  int m_cnt = 0;          // edges remaining until the outputs update
  bit m_done = 0, m_shown = 0, m_ovf = 0, m_led = 0, p_neg = 0;
  int m_t = 0, m_o = 0, p_mag = 0;

  always @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      m_cnt = 0; m_done = 0; m_shown = 0; m_ovf = 0; m_led = 0;
    end else begin
      m_done = 0;
      if (m_cnt == 0) begin
        if (start) begin
          p_neg = is_signed && (value >= 8'd128);
          p_mag = p_neg ? 256 - int'(value) : int'(value);
          m_cnt = 9;
        end
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_shown = 1; m_done = 1;
          m_led = p_neg;
          m_ovf = (p_mag > 99);
          m_t = (p_mag / 10) % 10;
          m_o = p_mag % 10;
        end
      end
    end
  end

  function automatic logic [6:0] exp_seg(bit blz, bit sal, bit tens);
    logic [6:0] r;
    int d;
    d = tens ? m_t : m_o;
    if (!m_shown)                   r = 7'b1111111;
    else if (m_ovf)                 r = 7'b0111111;
    else if (tens && blz && d == 0) r = 7'b1111111;
    else                            r = SEGT[d];
    return sal ? r : ~r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_busy", busy_a, m_cnt != 0);  chk("a_done", done_a, m_done);
      chk("a_led", led_a, m_led);         chk("a_ovf", ovf_a, m_ovf);
      chk("a_tens", tens_a, exp_seg(1, 1, 1)); chk("a_ones", ones_a, exp_seg(1, 1, 0));
      chk("b_busy", busy_b, m_cnt != 0);  chk("b_done", done_b, m_done);
      chk("b_led", led_b, m_led);         chk("b_ovf", ovf_b, m_ovf);
      chk("b_tens", tens_b, exp_seg(0, 1, 1)); chk("b_ones", ones_b, exp_seg(0, 1, 0));
      chk("c_busy", busy_c, m_cnt != 0);  chk("c_done", done_c, m_done);
      chk("c_led", led_c, m_led);         chk("c_ovf", ovf_c, m_ovf);
      chk("c_tens", tens_c, exp_seg(1, 0, 1)); chk("c_ones", ones_c, exp_seg(1, 0, 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One conversion; checks the start-to-done latency and returns one cycle after done.
  task automatic run(input logic [7:0] v, input bit s, input string name);
    int k;
    value = v; is_signed = s; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done_a) begin k = i; break; end
    end
    chk({name, "_latency"}, k, 9);
    tick();
  endtask

  initial begin
    int nd;
    #1 Reset = 1'b0;
    #1 chk_en = 1'b1;
    #98;
    chk("rst_busy", busy_a, 0); chk("rst_tens", tens_a, 7'b1111111);
    chk("rst_ones_c", ones_c, 7'b0000000); chk("rst_led", led_a, 0);
    @(posedge clk); #1 Reset = 1'b1;
    tick();

    run(8'd42, 0, "d42");
    chk("d42_tens", tens_a, 7'b0011001); chk("d42_ones", ones_a, 7'b0100100);
    chk("d42_led", led_a, 0); chk("d42_ovf", ovf_a, 0);
    chk("mdl42_t", m_t, 4); chk("mdl42_o", m_o, 2);

    run(8'hF9, 1, "sF9");
    chk("sF9_led", led_a, 1); chk("sF9_tens", tens_a, 7'b1111111);
    chk("sF9_ones", ones_a, 7'b1111000); chk("sF9_ovf", ovf_a, 0);
    run(8'hF9, 0, "uF9");
    chk("uF9_ovf", ovf_a, 1); chk("uF9_tens", tens_a, 7'b0111111);
    chk("uF9_ones", ones_a, 7'b0111111); chk("uF9_led", led_a, 0);
    run(8'd99, 0, "d99");
    chk("d99_tens", tens_a, 7'b0010000); chk("d99_ones", ones_a, 7'b0010000);
    run(8'd100, 0, "d100");
    chk("d100_ovf", ovf_a, 1); chk("d100_ones", ones_a, 7'b0111111);
    run(8'h80, 1, "s80");
    chk("s80_ovf", ovf_a, 1); chk("s80_led", led_a, 1); chk("s80_tens", tens_a, 7'b0111111);
    run(8'd0, 0, "d0");
    chk("d0_tens", tens_a, 7'b1111111); chk("d0_ones", ones_a, 7'b1000000);
    chk("d0_tens_b", tens_b, 7'b1000000);

    // start while busy is ignored
    value = 8'd42; is_signed = 0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    value = 8'd5; is_signed = 1; start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done_a) nd++;
    end
    chk("ign_done_cnt", nd, 1);
    chk("ign_tens", tens_a, 7'b0011001); chk("ign_ones", ones_a, 7'b0100100);

    // start accepted in the done cycle
    value = 8'd42; is_signed = 0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(9);
    chk("dc_done", done_a, 1);
    value = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    chk("dc_busy", busy_a, 1);
    tick(10);
    chk("dc_ones", ones_a, 7'b1111000); chk("dc_tens", tens_a, 7'b1111111);

    // reset in the 4th SHIFT cycle
    value = 8'd99; start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    Reset = 1'b0;
    #1;
    chk("mr_busy", busy_a, 0); chk("mr_tens", tens_a, 7'b1111111);
    chk("mr_ones", ones_a, 7'b1111111);
    tick(3);
    chk("mr_done", done_a, 0);
    Reset = 1'b1;
    tick();
    run(8'd13, 0, "d13");
    chk("d13_tens", tens_a, 7'b1111001); chk("d13_ones", ones_a, 7'b0110000);

    run(8'd3, 0, "d3");
    chk("d3_tens_b", tens_b, 7'b1000000); chk("d3_ones_b", ones_b, 7'b0110000);
    chk("d3_tens_c", tens_c, 7'b0000000); chk("d3_ones_c", ones_c, 7'b1001111);

    // randomized traffic: starts at random times, occasional resets
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      value = 8'($urandom);
      is_signed = 1'($urandom);
      if ($urandom_range(0, 400) == 0) Reset = 1'b0;
      else Reset = 1'b1;
      tick();
    end
    Reset = 1'b1; start = 1'b0;
    tick(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
